// File: rtl/karatsuba_pkg.sv
// Shared widths and defaults for the karatsuba_32 multiplier.
package karatsuba_pkg;
   localparam int HALF_W      = 16;
   localparam int OPER_W      = 32;
   localparam int PROD_W      = 64;
   localparam int MID_W       = 34;
   localparam int APPROX_DROP = 8;
endpackage

// File: rtl/karatsuba_mul17.sv
// 17x17 unsigned combinational multiplier, 34-bit product.
module karatsuba_mul17
   import karatsuba_pkg::*;
(
   input  logic [16:0]      i_a,
   input  logic [16:0]      i_b,
   output logic [MID_W-1:0] o_p
);
   assign o_p = MID_W'(i_a) * MID_W'(i_b);
endmodule

// File: rtl/karatsuba_32.sv
// Two-stage 32x32 Karatsuba multiplier; optional z0 truncation
// when KARATSUBA32_APPROX_EN is defined.
module karatsuba_32
   import karatsuba_pkg::*;
#(
   parameter int HALF_W      = karatsuba_pkg::HALF_W,
   parameter int APPROX_DROP = karatsuba_pkg::APPROX_DROP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [OPER_W-1:0] A,
   input  logic [OPER_W-1:0] B,
   output logic              out_valid,
   output logic [PROD_W-1:0] P
);
`ifdef KARATSUBA32_APPROX_EN
   localparam bit APPROX_EN = 1'b1;
`else
   localparam bit APPROX_EN = 1'b0;
`endif
   localparam int DROP = APPROX_EN ? APPROX_DROP : 0;
   localparam logic [MID_W-1:0] Z0_MASK =
      ~((MID_W'(1) << DROP) - MID_W'(1));

   logic [HALF_W-1:0] w_ah, w_al, w_bh, w_bl;
   logic [HALF_W:0]   w_sa, w_sb;
   logic [MID_W-1:0]  w_z2, w_z0, w_zm;
   logic [MID_W-1:0]  w_z1, w_z0_rec;
   logic [PROD_W-1:0] w_p;

   logic [MID_W-1:0]  r_z2, r_z0, r_zm;
   logic              r_v1;
   logic              r_out_valid;
   logic [PROD_W-1:0] r_p;

   assign w_ah = A[2*HALF_W-1 -: HALF_W];
   assign w_al = A[HALF_W-1:0];
   assign w_bh = B[2*HALF_W-1 -: HALF_W];
   assign w_bl = B[HALF_W-1:0];
   assign w_sa = {1'b0, w_ah} + {1'b0, w_al};
   assign w_sb = {1'b0, w_bh} + {1'b0, w_bl};

   karatsuba_mul17 u_mul_hi (
      .i_a ({1'b0, w_ah}),
      .i_b ({1'b0, w_bh}),
      .o_p (w_z2)
   );

   karatsuba_mul17 u_mul_lo (
      .i_a ({1'b0, w_al}),
      .i_b ({1'b0, w_bl}),
      .o_p (w_z0)
   );

   karatsuba_mul17 u_mul_mid (
      .i_a (w_sa),
      .i_b (w_sb),
      .o_p (w_zm)
   );

   // z1 always uses the exact z0; only the recombined z0 is truncated
   assign w_z1     = r_zm - r_z2 - r_z0;
   assign w_z0_rec = r_z0 & Z0_MASK;
   assign w_p      = (PROD_W'(r_z2) << (2*HALF_W))
                   + (PROD_W'(w_z1) << HALF_W)
                   + PROD_W'(w_z0_rec);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_z2        <= '0;
         r_z0        <= '0;
         r_zm        <= '0;
         r_v1        <= 1'b0;
         r_out_valid <= 1'b0;
         r_p         <= '0;
      end else begin
         r_v1        <= in_valid;
         r_out_valid <= r_v1;
         if (in_valid) begin
            r_z2 <= w_z2;
            r_z0 <= w_z0;
            r_zm <= w_zm;
         end
         if (r_v1) begin
            r_p <= w_p;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign P         = r_p;
endmodule

// File: tb/tb_karatsuba_32.sv
// Self-checking bench for karatsuba_32 against an arithmetic model.
module tb_karatsuba_32;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic [63:0] P;

   typedef struct {
      bit          v;
      logic [63:0] p;
   } ent_t;

   ent_t        hist[$];
   logic [63:0] held;
   int          n_assert;
   int          n_fail;

   karatsuba_32 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .P         (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] full;
      logic [31:0] lo;
      full = 64'(a) * 64'(b);
      lo   = 32'(a[15:0]) * 32'(b[15:0]);
`ifdef KARATSUBA32_APPROX_EN
      return full - 64'(lo[7:0]);
`else
      if (lo == 32'hFFFF_FFFF) full = full + 64'd0;
      return full;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock: drive, clock, record expectation, check output
   task automatic step(input bit r, input bit v, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] e,
                       input string tag);
      ent_t cur;
      ent_t prv;
      rst      = r;
      in_valid = v;
      A        = a;
      B        = b;
      @(posedge clk);
      #1;
      if (r) begin
         hist.delete();
         cur.v = 1'b0;
         cur.p = '0;
         hist.push_back(cur);
         hist.push_back(cur);
         held = '0;
      end else begin
         cur.v = v;
         cur.p = e;
         hist.push_back(cur);
      end
      prv = hist[hist.size()-2];
      if (prv.v) held = prv.p;
      chk({tag, ".valid"}, 64'(out_valid), 64'(prv.v));
      chk({tag, ".P"}, P, held);
      if (hist.size() > 4) void'(hist.pop_front());
   endtask

   task automatic op(input logic [31:0] a, input logic [31:0] b,
                     input string tag);
      step(1'b0, 1'b1, a, b, model(a, b), tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, $urandom, $urandom, 64'd0, tag);
   endtask

   logic [31:0] ra, rb;
   logic [63:0] full;
   logic [63:0] err;

   initial begin
      n_assert = 0;
      n_fail   = 0;
      held     = '0;
      rst      = 1'b1;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;

      step(1'b1, 1'b0, 32'd0, 32'd0, 64'd0, "reset0");
      step(1'b1, 1'b1, 32'd7, 32'd9, 64'd0, "reset1");
      chk("reset.P0", P, 64'd0);
      chk("reset.v0", 64'(out_valid), 64'd0);

      op(32'd12345, 32'd678, "flight0");
      op(32'hDEAD_BEEF, 32'h1234_5678, "flight1");
      step(1'b1, 1'b1, 32'd3, 32'd3, 64'd0, "flight_rst");
      idle("flush0");
      idle("flush1");
      idle("flush2");

`ifndef KARATSUBA32_APPROX_EN
      step(1'b0, 1'b1, 32'd65536, 32'd18, 64'd1179648, "dir0");
      step(1'b0, 1'b1, 32'd48584, 32'd54471, 64'd2646419064, "dir1");
      step(1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF, 64'd0, "dir2");
      step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, "corner_max");
`else
      step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0000, "corner_max");
      step(1'b0, 1'b1, 32'h0000_00FF, 32'h0000_00FF,
           64'h0000_0000_0000_FE00, "corner_ff");
      step(1'b0, 1'b1, 32'd65536, 32'd18, 64'd1179648, "dir0");
      step(1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF, 64'd0, "dir2");
`endif
      idle("drain0");
      idle("drain1");

      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) op($urandom, $urandom, "gap_on");
         else            idle("gap_off");
      end
      idle("gap_drain0");
      idle("gap_drain1");

      for (int i = 0; i < 2000; i++) begin
         case (i % 3)
            0: begin
               ra = $urandom_range(0, (1 << 10) - 1);
               rb = $urandom_range(0, (1 << 20) - 1);
            end
            1: begin
               ra = $urandom_range(0, (1 << 20) - 1);
               rb = $urandom_range(0, (1 << 20) - 1);
            end
            default: begin
               ra = $urandom;
               rb = $urandom;
            end
         endcase
         op(ra, rb, "rand");
`ifdef KARATSUBA32_APPROX_EN
         full = 64'(ra) * 64'(rb);
         err  = full - model(ra, rb);
         chk("rand_errbound", 64'(err <= 64'd255), 64'd1);
`endif
      end
      idle("end0");
      idle("end1");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/karatsuba_32.md
# karatsuba_32

Pipelined 32×32 unsigned multiplier producing a 64-bit product using one level of Karatsuba decomposition: three 16/17-bit partial multiplies instead of four. It is the datapath core of the approximate-multiplier evaluation flow. Benches feed it operand pairs and log `A, B, P` triples to compare exact and approximate builds. It has one clock domain, a fixed two-cycle latency, and a valid-tagged output.

## Interface
- `HALF_W`, default 16: operand half width. Fixed; the block is specified only for 16.
- `APPROX_DROP`, default 8: number of z0 LSBs forced to zero when approximation is compiled in.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: A/B are sampled this cycle.
- `A`  in  32: unsigned multiplicand.
- `B`  in  32: unsigned multiplier.
- `out_valid`  out  1: P holds a new result.
- `P`  out  64: unsigned product.

## Operation
- Operand split: AH=A[31:16], AL=A[15:0], BH=B[31:16], BL=B[15:0].
- Partial products:
  - z2 = AH·BH, 32 bits.
  - z0 = AL·BL, 32 bits.
  - zm = (AH+AL)·(BH+BL): 17-bit sums, 34-bit product.
- Middle term: z1 = zm − z2 − z0. Use a 34-bit unsigned subtract; the result is always ≥0 and <2^33.
- Recombination: P = (z2<<32) + (z1<<16) + z0, computed modulo 2^64. It never actually overflows, because the true product is <2^64.
- Default build is bit-exact: P == A·B for all inputs, including 0 and 0xFFFFFFFF.
- Inputs are unsigned only. No sign handling, no saturation.

## Timing
- Stage 1, edge k: if in_valid, register z2, z0 and zm, and set the stage-1 valid flag. Otherwise clear the valid flag; data registers may hold.
- Stage 2, edge k+1: register z1, the recombined P, and out_valid.
- Latency: A/B sampled at edge k give P and out_valid=1 after edge k+1, i.e. two rising edges. Throughput is one operation per cycle.
- P holds its last value while out_valid=0.
- Back-to-back in_valid: each cycle's result appears exactly two edges later, in order, with no bubbles.
- Reset: at any edge with rst=1, all pipeline registers clear.
  - After that edge: P=0, out_valid=0.
  - In-flight operations are discarded; nothing emerges after rst deasserts.
  - If in_valid=1 on the same edge as rst=1, rst wins.
- No backpressure. The consumer must accept results when out_valid=1.

## Configuration
- `KARATSUBA32_APPROX_EN` undefined: exact multiplier as above.
- `KARATSUBA32_APPROX_EN` defined: single-approximation mode.
  - Only z0 is approximated. Its APPROX_DROP LSBs are forced to 0 before recombination, i.e. z0' = z0 & ~(2^APPROX_DROP−1).
  - The z1 computation still uses the exact z0.
  - Error: P = A·B − (z0 mod 2^APPROX_DROP), so 0 ≤ error ≤ 255.
  - Latency and handshake are unchanged.

## Structure
- Package `karatsuba_pkg`:
  - width constants: HALF_W=16, OPER_W=32, PROD_W=64, MID_W=34.
  - the default APPROX_DROP.
- Sub-module `karatsuba_mul17`: 17×17 unsigned combinational multiplier with a 34-bit output.
  - Instantiated three times; z2 and z0 use it with the MSB tied to 0.
- Top `karatsuba_32` holds the split, the pipeline registers, the subtraction, the recombination and the approximation mux.

## Test plan
- Reset: hold rst for 2 cycles, then check P=0 and out_valid=0. Apply rst while 2 operations are in flight; neither result may appear.
- Directed exact checks, one per cycle (back-to-back). Each must appear 2 edges later, in order:
  - 65536×18 → 1179648.
  - 48584×54471 → 2646419064.
  - 0×0xFFFFFFFF → 0.
- Corner, exact build: 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE00000001. Confirms z1 fits 34 bits and carries propagate.
- Corner, KARATSUBA32_APPROX_EN build: same operands → 0xFFFFFFFE00000000. Also 0x000000FF×0x000000FF → 0xFE00 (exact product 0xFE01).
- Random, 2000 pairs, mirroring the logging flow:
  - ranges: A<2^10 with B<2^20; A,B<2^20; full 32-bit.
  - exact build: check P==A·B.
  - approx build: check 0 ≤ A·B−P ≤ 255, with the error equal to (AL·BL) mod 256.
- in_valid gaps: alternate in_valid 1/0. out_valid must toggle with the same pattern two cycles later, and P must hold during gaps.
